// File: rtl/sdram_addr_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : sdram_addr_pkg
 * Brief    : Shared SDRAM address geometry and traversal FSM encodings.
 * Revision : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

package sdram_addr_pkg;

    localparam int BA_W     = 2;
    localparam int ROW_W    = 13;
    localparam int COL_W    = 9;
    localparam int ADDR_W   = 24;
    localparam int NUM_ROWS = 1 << ROW_W;
    localparam int NUM_COLS = 1 << COL_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } trav_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_addr_counter.sv
/*------------------------------------------------------------------------------
 * Module   : sdram_addr_counter
 * Brief    : {bank, row, column} pointer stepping one burst per enable.
 * Revision : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module sdram_addr_counter
    import sdram_addr_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [BA_W-1:0]  o_ba,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col
);

    localparam logic [COL_W:0]   c_STEP     = (COL_W+1)'(BURST_LEN);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS - 1);

    logic [BA_W-1:0]  r_ba;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [COL_W:0]   w_col_sum;

    // Carry out of the column sum marks the end of the row.
    assign w_col_sum = {1'b0, r_col} + c_STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ba  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_sum[COL_W]) begin
                r_col <= '0;
                if (r_row == c_LAST_ROW) begin
                    r_row <= '0;
                    r_ba  <= r_ba + BA_W'(1);
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= w_col_sum[COL_W-1:0];
            end
        end
    end

    assign o_ba  = r_ba;
    assign o_row = r_row;
    assign o_col = r_col;

endmodule

`default_nettype wire

// File: rtl/sdram_write_address_traversal.sv
/*------------------------------------------------------------------------------
 * Module   : sdram_write_address_traversal
 * Brief    : Write-side ring-buffer address generator with occupancy flags.
 * Revision : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module sdram_write_address_traversal
    import sdram_addr_pkg::*;
#(
    parameter int BURST_LEN          = 8,
    parameter int ALMOST_FULL_BURSTS = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             WR_NEXT,
    input  logic             RD_NEXT,
    output logic [BA_W-1:0]  BA_WRITE_OUT,
    output logic [ROW_W-1:0] ROW_WRITE_OUT,
    output logic [COL_W-1:0] COL_WRITE_OUT,
    output logic             WR_ACK,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int CAP_LOG2 = ADDR_W - $clog2(BURST_LEN);
    localparam int CNT_W    = CAP_LOG2 + 1;

    localparam logic [CNT_W-1:0] c_CAPACITY = {1'b1, {CAP_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_AF_LIMIT = CNT_W'(ALMOST_FULL_BURSTS);

    trav_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_wr_ack, r_almost_full, r_overflow, r_underflow;
    logic             w_wr_acc, w_rd_acc;
    logic [CNT_W-1:0] w_free_nxt;

    always_comb begin
        w_wr_acc    = WR_NEXT & (r_state != S_FULL);
        w_rd_acc    = RD_NEXT & (r_state != S_EMPTY);
        w_count_nxt = r_count;
        w_state_nxt = r_state;

        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - c_ONE;
        end

        case (r_state)
            S_EMPTY: if (w_wr_acc) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_rd_acc && !w_wr_acc && r_count == c_ONE) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_wr_acc && !w_rd_acc && r_count == c_CAPACITY - c_ONE) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL:  if (w_rd_acc) w_state_nxt = S_FILL;
            default: w_state_nxt = S_EMPTY;
        endcase

        w_free_nxt = c_CAPACITY - w_count_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state       <= S_EMPTY;
            r_count       <= '0;
            r_wr_ack      <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_wr_ack      <= w_wr_acc;
            r_almost_full <= (w_free_nxt <= c_AF_LIMIT);
            // Error flags are sticky until the next reset.
            r_overflow    <= r_overflow  | (WR_NEXT & (r_state == S_FULL));
            r_underflow   <= r_underflow | (RD_NEXT & (r_state == S_EMPTY));
        end
    end

    sdram_addr_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_addr_counter (
        .clk   (CLK),
        .rst_n (RESET_N),
        .i_en  (w_wr_acc),
        .o_ba  (BA_WRITE_OUT),
        .o_row (ROW_WRITE_OUT),
        .o_col (COL_WRITE_OUT)
    );

    assign WR_ACK      = r_wr_ack;
    assign FULL        = (r_state == S_FULL);
    assign EMPTY       = (r_state == S_EMPTY);
    assign ALMOST_FULL = r_almost_full;
    assign OVERFLOW    = r_overflow;
    assign UNDERFLOW   = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sdram_write_address_traversal.sv
/*------------------------------------------------------------------------------
 * Module   : tb_sdram_write_address_traversal
 * Brief    : Scoreboard bench for the write traversal (BURST_LEN 8 and 512).
 * Revision : 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_sdram_write_address_traversal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
    logic        rn_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
    logic [1:0]  ba_a, ba_b;
    logic [12:0] row_a, row_b;
    logic [8:0]  col_a, col_b;
    logic        ack_a, full_a, empty_a, af_a, ovf_a, unf_a;
    logic        ack_b, full_b, empty_b, af_b, ovf_b, unf_b;
    logic [29:0] out_a, out_b;

    sdram_write_address_traversal #(.BURST_LEN(8), .ALMOST_FULL_BURSTS(16)) u_dut_a (
        .CLK(clk), .RESET_N(rn_a), .WR_NEXT(wr_a), .RD_NEXT(rd_a),
        .BA_WRITE_OUT(ba_a), .ROW_WRITE_OUT(row_a), .COL_WRITE_OUT(col_a),
        .WR_ACK(ack_a), .FULL(full_a), .EMPTY(empty_a), .ALMOST_FULL(af_a),
        .OVERFLOW(ovf_a), .UNDERFLOW(unf_a)
    );

    sdram_write_address_traversal #(.BURST_LEN(512), .ALMOST_FULL_BURSTS(16)) u_dut_b (
        .CLK(clk), .RESET_N(rn_b), .WR_NEXT(wr_b), .RD_NEXT(rd_b),
        .BA_WRITE_OUT(ba_b), .ROW_WRITE_OUT(row_b), .COL_WRITE_OUT(col_b),
        .WR_ACK(ack_b), .FULL(full_b), .EMPTY(empty_b), .ALMOST_FULL(af_b),
        .OVERFLOW(ovf_b), .UNDERFLOW(unf_b)
    );

    assign out_a = {ba_a, row_a, col_a, ack_a, full_a, empty_a, af_a, ovf_a, unf_a};
    assign out_b = {ba_b, row_b, col_b, ack_b, full_b, empty_b, af_b, ovf_b, unf_b};

    typedef struct {
        string       tag;
        int          inst;
        logic [29:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: linear burst index, occupancy and sticky flags per instance.
    longint unsigned m_p[2];
    longint unsigned m_cnt[2];
    bit              m_ack[2], m_ovf[2], m_unf[2];

    function automatic longint unsigned bl_of(int i);
        return (i == 1) ? 64'd512 : 64'd8;
    endfunction

    function automatic logic [29:0] model_out(int i);
        longint unsigned cap = 64'd16777216 / bl_of(i);
        logic [23:0] w;
        w = 24'((m_p[i] * bl_of(i)) % 64'd16777216);
        return {w[23:22], w[21:9], w[8:0], m_ack[i], (m_cnt[i] == cap),
                (m_cnt[i] == 0), ((cap - m_cnt[i]) <= 16), m_ovf[i], m_unf[i]};
    endfunction

    task automatic step(input int inst, input bit wr, input bit rd, input bit rstn,
                        input string tag);
        longint unsigned cap;
        bit   wa, ra;
        exp_t e;
        logic [29:0] obs;
        cap = 64'd16777216 / bl_of(inst);
        @(negedge clk);
        rn_a = 1'b1; wr_a = 1'b0; rd_a = 1'b0;
        rn_b = 1'b1; wr_b = 1'b0; rd_b = 1'b0;
        if (inst == 0) begin rn_a = rstn; wr_a = wr; rd_a = rd; end
        else           begin rn_b = rstn; wr_b = wr; rd_b = rd; end
        if (!rstn) begin
            m_p[inst] = 0; m_cnt[inst] = 0;
            m_ack[inst] = 0; m_ovf[inst] = 0; m_unf[inst] = 0;
        end else begin
            wa = wr && (m_cnt[inst] != cap);
            ra = rd && (m_cnt[inst] != 0);
            if (wr && m_cnt[inst] == cap) m_ovf[inst] = 1;
            if (rd && m_cnt[inst] == 0)   m_unf[inst] = 1;
            if (wa && !ra) m_cnt[inst]++;
            if (ra && !wa) m_cnt[inst]--;
            if (wa) m_p[inst]++;
            m_ack[inst] = wa;
        end
        sb.push_back('{tag: tag, inst: inst, val: model_out(inst)});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = (e.inst == 1) ? out_b : out_a;
        n_vec++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (ba,row,col,ack,full,empty,af,ovf,unf)",
                   e.tag, obs, e.val);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Instance A: BURST_LEN = 8
        step(0, 0, 0, 0, "reset_a");
        step(0, 0, 0, 0, "reset_a_hold");
        step(0, 0, 1, 1, "rd_after_reset_underflow");
        step(0, 0, 0, 1, "underflow_sticky");
        step(0, 0, 0, 0, "reset_clears_underflow");
        step(0, 1, 0, 1, "single_write");
        step(0, 0, 0, 1, "ack_single_cycle");
        for (int k = 0; k < 63; k++) step(0, 1, 0, 1, "b2b_write_row_wrap");
        step(0, 0, 0, 0, "reset_before_concurrent");
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1, "fill_to_5");
        step(0, 1, 1, 1, "concurrent_wr_rd");
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, "drain_to_empty");
        step(0, 0, 1, 1, "rd_on_empty_underflow");
        step(0, 0, 0, 0, "reset_before_midstream");
        for (int k = 0; k < 10; k++) step(0, 1, 0, 1, "fill_to_10");
        step(0, 1, 0, 0, "reset_with_wr_next");
        step(0, 0, 0, 1, "idle_after_reset");

        // Instance B: BURST_LEN = 512, capacity 32768 bursts
        step(1, 0, 0, 0, "reset_b");
        for (int k = 0; k < 32768; k++) step(1, 1, 0, 1, "fill_to_full");
        step(1, 1, 0, 1, "write_while_full_overflow");
        step(1, 1, 1, 1, "wr_rd_while_full");
        step(1, 1, 0, 1, "refill_after_read");
        step(1, 0, 0, 1, "idle_full");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
